// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier sequencer states, width and latency constants.
package alu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_LOAD,
    S_RUN,
    S_CAPT,
    S_DONE
  } mul_state_e;

  localparam int MUL_WIDTH   = 16;
  localparam int MUL_LATENCY = 19;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/booth_core.sv
// Radix-2 sequential Booth multiplier core: sync reset, load, then WIDTH step edges.
module booth_core #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   q,
  output logic [2*WIDTH-1:0] p
);

  // One guard bit on the accumulator keeps -M of the most negative M representable.
  logic signed [WIDTH:0] acc;
  logic signed [WIDTH:0] m_ext;
  logic signed [WIDTH:0] sum;
  logic [WIDTH-1:0]      qr;
  logic                  q_1;
  logic [CNT_W-1:0]      steps;

  always_comb begin
    sum = acc;
    case ({qr[0], q_1})
      2'b01:   sum = acc + m_ext;
      2'b10:   sum = acc - m_ext;
      default: sum = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      m_ext <= '0;
      qr    <= '0;
      q_1   <= 1'b0;
      steps <= CNT_W'(WIDTH);
    end else if (load) begin
      acc   <= '0;
      m_ext <= {m[WIDTH-1], m};
      qr    <= q;
      q_1   <= 1'b0;
      steps <= '0;
    end else if (steps != CNT_W'(WIDTH)) begin
      acc   <= {sum[WIDTH], sum[WIDTH:1]};
      qr    <= {sum[0], qr[WIDTH-1:1]};
      q_1   <= qr[0];
      steps <= steps + CNT_W'(1);
    end
  end

  assign p = {acc[WIDTH-1:0], qr};

endmodule

// File: rtl/booth_mul_seq.sv
// Operand handshake, core reset/load sequencing and product capture for the Booth core.
module booth_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [WIDTH-1:0]   op_m,
  input  logic [WIDTH-1:0]   op_q,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_p,
  output logic               res_ovf,
  output logic               res_zero,
  output logic               busy,
  output logic               mul_reset,
  output logic               mul_load,
  output logic [WIDTH-1:0]   mul_m,
  output logic [WIDTH-1:0]   mul_q,
  input  logic [2*WIDTH-1:0] mul_p
);

  localparam int PW = prod_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_ready_d, res_valid_d, res_ovf_d, res_zero_d, busy_d;
  logic              mul_reset_d, mul_load_d;
  logic [PW-1:0]     res_p_d;
  logic [WIDTH-1:0]  mul_m_d, mul_q_d;

  // Signed product fits WIDTH bits only when its top WIDTH+1 bits are all sign copies.
  function automatic logic ovf_of(input logic signed [PW-1:0] p);
    logic [WIDTH:0] top;
    top = p[PW-1:WIDTH-1];
    return !((&top) || !(|top));
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_ready_d  = op_ready;
    res_valid_d = res_valid;
    res_p_d     = res_p;
    res_ovf_d   = res_ovf;
    res_zero_d  = res_zero;
    mul_reset_d = mul_reset;
    mul_load_d  = 1'b0;
    mul_m_d     = mul_m;
    mul_q_d     = mul_q;
    case (state_q)
      S_IDLE: begin
        op_ready_d  = 1'b1;
        mul_reset_d = 1'b0;
        if (op_valid) begin
          mul_m_d     = op_m;
          mul_q_d     = op_q;
          op_ready_d  = 1'b0;
          mul_reset_d = 1'b1;
          state_d     = S_RST;
        end
      end
      S_RST: begin
        mul_reset_d = 1'b0;
        mul_load_d  = 1'b1;
        state_d     = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) state_d = S_CAPT;
      end
      S_CAPT: begin
        res_p_d     = mul_p;
        res_ovf_d   = ovf_of(mul_p);
        res_zero_d  = (mul_p == '0);
        res_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          op_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_p     <= '0;
      res_ovf   <= 1'b0;
      res_zero  <= 1'b0;
      busy      <= 1'b0;
      mul_reset <= 1'b1;
      mul_load  <= 1'b0;
      mul_m     <= '0;
      mul_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_ready  <= op_ready_d;
      res_valid <= res_valid_d;
      res_p     <= res_p_d;
      res_ovf   <= res_ovf_d;
      res_zero  <= res_zero_d;
      busy      <= busy_d;
      mul_reset <= mul_reset_d;
      mul_load  <= mul_load_d;
      mul_m     <= mul_m_d;
      mul_q     <= mul_q_d;
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq driving the real Booth core, with an arithmetic product model.
module tb_booth_mul_seq;
  import alu_pkg::*;

  localparam int W = MUL_WIDTH;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            op_valid = 1'b0;
  logic            op_ready;
  logic [W-1:0]    op_m = '0;
  logic [W-1:0]    op_q = '0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [2*W-1:0]  res_p;
  logic            res_ovf;
  logic            res_zero;
  logic            busy;
  logic            mul_reset;
  logic            mul_load;
  logic [W-1:0]    mul_m;
  logic [W-1:0]    mul_q;
  logic [2*W-1:0]  mul_p;

  int n_checks = 0;
  int n_err = 0;

  booth_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_m(op_m), .op_q(op_q),
    .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p),
    .res_ovf(res_ovf), .res_zero(res_zero), .busy(busy),
    .mul_reset(mul_reset), .mul_load(mul_load), .mul_m(mul_m), .mul_q(mul_q),
    .mul_p(mul_p)
  );

  booth_core #(.WIDTH(W)) core (
    .clk(clk), .reset(mul_reset), .load(mul_load), .m(mul_m), .q(mul_q), .p(mul_p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] p;
    logic           ovf;
    logic           zero;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model_p(input logic [W-1:0] m, input logic [W-1:0] q);
    int a, b;
    a = $signed(m);
    b = $signed(q);
    return 32'(a * b);
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] m, input logic [W-1:0] q);
    int a, b, r;
    a = $signed(m);
    b = $signed(q);
    r = a * b;
    return (r > 32767) || (r < -32768);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_op(input logic [W-1:0] m, input logic [W-1:0] q);
    bit done = 0;
    op_m = m;
    op_q = q;
    op_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (op_ready) begin
        tick();
        done = 1;
        break;
      end
      tick();
    end
    op_valid = 1'b0;
    op_m = W'($urandom);
    op_q = W'($urandom);
    if (!done) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      lat++;
      if (res_valid) break;
    end
    if (!res_valid) check("result_timeout", 64'd0, 64'd1);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] m, input logic [W-1:0] q);
    check({tag, "_p"},    64'(res_p),    64'(model_p(m, q)));
    check({tag, "_ovf"},  64'(res_ovf),  64'(model_ovf(m, q)));
    check({tag, "_zero"}, 64'(res_zero), 64'(model_p(m, q) == '0));
  endtask

  initial begin
    int lat;
    logic [W-1:0] rm, rq;
    logic [2*W-1:0] held_p;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFD, 16'h0005, 32'hFFFFFFF1, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h8000, 32'h40000000, 1'b1, 1'b0};
    vecs[3] = '{16'h0000, 16'h1234, 32'h00000000, 1'b0, 1'b1};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 32'hFFFF8001, 1'b0, 1'b0};
    vecs[5] = '{16'h0006, 16'hFFF9, 32'hFFFFFFD6, 1'b0, 1'b0};

    // Reset held low while the clock runs.
    repeat (3) tick();
    check("rst_op_ready", 64'(op_ready), 64'd1);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_p", 64'(res_p), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mul_reset", 64'(mul_reset), 64'd1);
    check("rst_mul_load", 64'(mul_load), 64'd0);
    check("rst_mul_m", 64'(mul_m), 64'd0);
    reset = 1'b1;
    tick();
    check("idle_mul_reset", 64'(mul_reset), 64'd0);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      accept_op(vecs[i].m, vecs[i].q);
      check("accept_busy", 64'(busy), 64'd1);
      wait_result(lat);
      check("latency", 64'(lat), 64'(MUL_LATENCY));
      check("tbl_p", 64'(res_p), 64'(vecs[i].p));
      check("tbl_ovf", 64'(res_ovf), 64'(vecs[i].ovf));
      check("tbl_zero", 64'(res_zero), 64'(vecs[i].zero));
      consume();
      check("consume_valid", 64'(res_valid), 64'd0);
      check("consume_ready", 64'(op_ready), 64'd1);
    end

    // Backpressure with a competing op offered during DONE.
    accept_op(16'h0011, 16'h0013);
    wait_result(lat);
    held_p = res_p;
    op_m = 16'h0021;
    op_q = 16'hFFFE;
    op_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_res_p", 64'(res_p), 64'(held_p));
      check("bp_valid", 64'(res_valid), 64'd1);
      check("bp_op_ready", 64'(op_ready), 64'd0);
      check("bp_mul_m", 64'(mul_m), 64'h0011);
    end
    check_res("bp", 16'h0011, 16'h0013);
    consume();
    check("bp_release_ready", 64'(op_ready), 64'd1);
    check("bp_release_valid", 64'(res_valid), 64'd0);
    tick();
    op_valid = 1'b0;
    check("bp_next_accept", 64'(mul_m), 64'h0021);
    check("bp_next_busy", 64'(busy), 64'd1);
    wait_result(lat);
    check("bp_next_lat", 64'(lat), 64'(MUL_LATENCY));
    check_res("bp_next", 16'h0021, 16'hFFFE);
    consume();

    // Reset in the middle of RUN.
    accept_op(16'h0007, 16'h0009);
    repeat (2 + 8) tick();
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(res_valid), 64'd0);
    check("mid_rst_ready", 64'(op_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_res_p", 64'(res_p), 64'd0);
    check("mid_rst_mul_m", 64'(mul_m), 64'd0);
    check("mid_rst_mul_reset", 64'(mul_reset), 64'd1);
    repeat (2) tick();
    check("mid_rst_hold", 64'(mul_reset), 64'd1);
    reset = 1'b1;
    repeat (25) begin
      tick();
      if (res_valid) break;
    end
    check("no_partial_result", 64'(res_valid), 64'd0);
    accept_op(16'h0006, 16'hFFF9);
    wait_result(lat);
    check("post_rst_lat", 64'(lat), 64'(MUL_LATENCY));
    check("post_rst_p", 64'(res_p), 64'hFFFFFFD6);
    consume();

    // Back-to-back: second accept one edge after the first result is consumed.
    accept_op(16'h0002, 16'h0002);
    wait_result(lat);
    check("b2b_first_p", 64'(res_p), 64'h00000004);
    op_m = 16'hFFFF;
    op_q = 16'hFFFF;
    op_valid = 1'b1;
    consume();
    check("b2b_gap_ready", 64'(op_ready), 64'd1);
    tick();
    op_valid = 1'b0;
    check("b2b_accept_m", 64'(mul_m), 64'hFFFF);
    check("b2b_accept_busy", 64'(busy), 64'd1);
    wait_result(lat);
    check("b2b_second_p", 64'(res_p), 64'h00000001);
    consume();

    // Randomized operands, biased toward the signed extremes.
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 4))
        0: rm = 16'h8000;
        1: rm = 16'h7FFF;
        default: rm = W'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: rq = 16'hFFFF;
        1: rq = 16'h0000;
        default: rq = W'($urandom);
      endcase
      accept_op(rm, rq);
      wait_result(lat);
      check("rnd_lat", 64'(lat), 64'(MUL_LATENCY));
      check_res("rnd", rm, rq);
      repeat ($urandom_range(0, 3)) tick();
      check("rnd_hold_p", 64'(res_p), 64'(model_p(rm, rq)));
      consume();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
